fir_mm_responder: RTL and testbench
===================================

FIR_MM_RESPONDER -- requirements
Module: fir_mm_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample/coefficient width (8..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per sample FIFO (power of 2, 4..64).
REQ-003 SHALL have parameter COEF_N, default 64, meaning coefficient slots (power of 2, max 64).
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports: clk_clk in 1 system clock; reset_reset in 1 synchronous active-high reset.
REQ-005 SHALL have Avalon-MM slave ports: avs_address in 10 byte address; avs_read in 1; avs_write in 1; avs_writedata in 32; avs_byteenable in 4; avs_burstcount in 1 (always 1); avs_debugaccess in 1 (ignored); avs_waitrequest out 1; avs_readdata out 32; avs_readdatavalid out 1.
REQ-006 SHALL have stream ports: tx_data out DATA_W; tx_valid out 1; tx_ready in 1 (samples to FIR core); rx_data in DATA_W; rx_valid in 1 (results from FIR core, no backpressure).
REQ-007 SHALL have coefficient port: coef_we out 1; coef_addr out log2(COEF_N); coef_data out DATA_W.

Function
REQ-008 SHALL decode word index avs_address[9:2]; address bits [1:0] ignored.
REQ-009 SHALL map: 0x000 CTRL RW (bit0 enable, bit1 clear self-clearing); 0x004 STATUS RO; 0x008 SAMPLE_IN WO; 0x00C SAMPLE_OUT RO; 0x100+4k COEF[k] WO, k < COEF_N; all other addresses read 0, writes dropped.
REQ-010 SHALL apply CTRL writes per byte lane via avs_byteenable; SAMPLE_IN and COEF writes take effect only when avs_byteenable[1:0] covers DATA_W bits, otherwise dropped.
REQ-011 SHALL assert avs_waitrequest combinationally only for a SAMPLE_IN write while the input FIFO is full; all other accesses complete with waitrequest low.
REQ-012 SHALL return read data with fixed latency 2: avs_readdatavalid high exactly 2 cycles after the accepting cycle; back-to-back reads pipeline one per cycle.
REQ-013 SHALL format STATUS as [7:0] input level, [15:8] output level, bit16 in_full, bit17 out_empty, bit18 overflow sticky, bit19 underflow sticky; a STATUS read clears both sticky bits after capture.
REQ-014 SHALL pop SAMPLE_OUT on read acceptance, returning sign-extended rx sample; when empty returns 0, sets underflow, no pop.
REQ-015 SHALL drive tx_valid when CTRL.enable=1 and input FIFO non-empty; pop on tx_valid&tx_ready; tx_data stable while tx_valid&!tx_ready.
REQ-016 SHALL push rx_data on rx_valid when output FIFO not full; when full, drop sample and set overflow.
REQ-017 SHALL, on simultaneous push and pop of the same FIFO, keep level unchanged, including at full and empty.
REQ-018 SHALL pulse coef_we one cycle, registered, one cycle after an accepted COEF write, with coef_addr=k and coef_data=writedata[DATA_W-1:0].
REQ-019 SHALL, on CTRL.clear, empty both FIFOs and clear sticky bits in the next cycle; a same-cycle rx_valid push is discarded.
REQ-020 SHALL use wrap-around pointers of log2(FIFO_DEPTH)+1 bits; level = wptr - rptr.

Reset
REQ-021 SHALL on reset_reset: FIFOs empty, CTRL=0, sticky bits 0, tx_valid=0, coef_we=0, avs_readdatavalid=0, avs_readdata=0, read pipeline flushed.
REQ-022 SHALL discard any in-flight read on reset mid-operation; no readdatavalid appears for it.

Configuration
REQ-023 SHALL, with FIR_MM_RESPONDER_IRQ_EN defined, add output irq (1 bit), CTRL bit2 irq enable, irq = enable & (out level>0 | overflow), registered; without the macro no irq port exists and CTRL bit2 reads 0.

Structure
REQ-024 SHALL place register offsets, STATUS bit positions and CTRL bit positions in shared package fir_mm_pkg.
REQ-025 SHALL instantiate sub-module fir_mm_fifo twice (input and output FIFO), parameterised by DATA_W and FIFO_DEPTH.

Verification
REQ-026 SHALL cover: write CTRL=0x1, read CTRL -> readdata 0x00000001 with readdatavalid exactly 2 cycles after read.
REQ-027 SHALL cover: tx_ready=0, 17 SAMPLE_IN writes with FIFO_DEPTH=16 -> 17th holds waitrequest until tx_ready=1 for one cycle, then completes; STATUS in_full observed before.
REQ-028 SHALL cover: rx_valid with rx_data 0x8001 for 17 cycles, DATA_W=16 -> STATUS out level 16, overflow=1; SAMPLE_OUT read returns 0xFFFF8001; second STATUS read shows overflow=0.
REQ-029 SHALL cover: COEF write to 0x10C with data 0x1234 -> coef_we one cycle later, coef_addr=3, coef_data=0x1234.
REQ-030 SHALL cover: read SAMPLE_OUT when empty -> readdata 0, underflow=1; reset asserted one cycle after a read -> no readdatavalid follows.

Source files
------------

// File: rtl/fir_mm_pkg.sv
// rtl/fir_mm_pkg.sv - register map, CTRL/STATUS bit positions and decode helpers for fir_mm_responder
package fir_mm_pkg;

    localparam logic [7:0] REG_CTRL       = 8'h00;
    localparam logic [7:0] REG_STATUS     = 8'h01;
    localparam logic [7:0] REG_SAMPLE_IN  = 8'h02;
    localparam logic [7:0] REG_SAMPLE_OUT = 8'h03;
    localparam logic [7:0] REG_COEF_BASE  = 8'h40;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_IN_LEVEL  = 0;
    localparam int ST_OUT_LEVEL = 8;
    localparam int ST_IN_FULL   = 16;
    localparam int ST_OUT_EMPTY = 17;
    localparam int ST_OVERFLOW  = 18;
    localparam int ST_UNDERFLOW = 19;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_STATUS,
        SEL_SAMPLE_IN,
        SEL_SAMPLE_OUT,
        SEL_COEF
    } reg_sel_e;

    // byte lanes that must be enabled for a write to carry a full sample
    function automatic logic [3:0] lane_mask(input int width);
        return 4'((1 << ((width + 7) / 8)) - 1);
    endfunction

endpackage

// File: rtl/fir_mm_fifo.sv
// rtl/fir_mm_fifo.sv - show-ahead sample FIFO with wrap-bit pointers and synchronous clear
module fir_mm_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              do_push;
    logic              do_pop;

    assign level    = wptr - rptr;
    assign full     = (level == LVL_W'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign pop_data = mem[rptr[AW-1:0]];

    // a pop in the same cycle frees the slot, so a full FIFO still takes the push
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fir_mm_responder.sv
// rtl/fir_mm_responder.sv - Avalon-MM register front end for an FIR core; optional irq via FIR_MM_RESPONDER_IRQ_EN
import fir_mm_pkg::*;

module fir_mm_responder #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int COEF_N     = 64
) (
    input  logic                                        clk_clk,
    input  logic                                        reset_reset,
    input  logic [9:0]                                  avs_address,
    input  logic                                        avs_read,
    input  logic                                        avs_write,
    input  logic [31:0]                                 avs_writedata,
    input  logic [3:0]                                  avs_byteenable,
    input  logic                                        avs_burstcount,
    input  logic                                        avs_debugaccess,
    output logic                                        avs_waitrequest,
    output logic [31:0]                                 avs_readdata,
    output logic                                        avs_readdatavalid,
    output logic [DATA_W-1:0]                           tx_data,
    output logic                                        tx_valid,
    input  logic                                        tx_ready,
    input  logic [DATA_W-1:0]                           rx_data,
    input  logic                                        rx_valid,
    output logic                                        coef_we,
    output logic [((COEF_N > 1) ? $clog2(COEF_N) : 1)-1:0] coef_addr,
    output logic [DATA_W-1:0]                           coef_data
`ifdef FIR_MM_RESPONDER_IRQ_EN
    ,
    output logic                                        irq
`endif
);

    localparam int         CA_W      = (COEF_N > 1) ? $clog2(COEF_N) : 1;
    localparam int         LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] LANE_MASK = lane_mask(DATA_W);

    logic [7:0]        word;
    logic [7:0]        coef_idx;
    reg_sel_e          sel;
    logic              wr_accept;
    logic              rd_accept;
    logic              lanes_ok;
    logic              ctrl_wr;
    logic              coef_wr;
    logic              in_push;
    logic              rd_status;
    logic              rd_sample_out;
    logic              ovf_event;
    logic              unf_event;

    logic              enable;
    logic              clear_pulse;
    logic              irq_bit;
    logic              overflow;
    logic              underflow;

    logic              in_full, in_empty, out_full, out_empty;
    logic [LVL_W-1:0]  in_level, out_level;
    logic [DATA_W-1:0] out_data;

    logic [31:0]       status;
    logic [31:0]       rd_mux;
    logic              rd_valid1;
    logic [31:0]       rd_data1;

    logic              unused_ok;
    assign unused_ok = &{1'b0, avs_address[1:0], avs_burstcount, avs_debugaccess,
                         avs_writedata, avs_byteenable, coef_idx};

    assign word = avs_address[9:2];

    always_comb begin
        sel      = SEL_NONE;
        coef_idx = word - REG_COEF_BASE;
        case (word)
            REG_CTRL:       sel = SEL_CTRL;
            REG_STATUS:     sel = SEL_STATUS;
            REG_SAMPLE_IN:  sel = SEL_SAMPLE_IN;
            REG_SAMPLE_OUT: sel = SEL_SAMPLE_OUT;
            default: begin
                if (word >= REG_COEF_BASE && coef_idx < 8'(COEF_N)) sel = SEL_COEF;
            end
        endcase
    end

    // only a sample push into a full input FIFO stalls the bus
    assign avs_waitrequest = avs_write & (word == REG_SAMPLE_IN) & in_full;

    assign wr_accept     = avs_write & ~avs_waitrequest;
    assign rd_accept     = avs_read & ~avs_waitrequest;
    assign lanes_ok      = (avs_byteenable & LANE_MASK) == LANE_MASK;
    assign ctrl_wr       = wr_accept & (sel == SEL_CTRL) & avs_byteenable[0];
    assign coef_wr       = wr_accept & (sel == SEL_COEF) & lanes_ok;
    assign in_push       = wr_accept & (sel == SEL_SAMPLE_IN) & lanes_ok;
    assign rd_status     = rd_accept & (sel == SEL_STATUS);
    assign rd_sample_out = rd_accept & (sel == SEL_SAMPLE_OUT);
    assign ovf_event     = rx_valid & out_full & ~rd_sample_out;
    assign unf_event     = rd_sample_out & out_empty;

    assign tx_valid = enable & ~in_empty;

    fir_mm_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk       (clk_clk),
        .reset     (reset_reset),
        .clear     (clear_pulse),
        .push      (in_push),
        .push_data (avs_writedata[DATA_W-1:0]),
        .pop       (tx_valid & tx_ready),
        .pop_data  (tx_data),
        .full      (in_full),
        .empty     (in_empty),
        .level     (in_level)
    );

    fir_mm_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk       (clk_clk),
        .reset     (reset_reset),
        .clear     (clear_pulse),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rd_sample_out),
        .pop_data  (out_data),
        .full      (out_full),
        .empty     (out_empty),
        .level     (out_level)
    );

`ifdef FIR_MM_RESPONDER_IRQ_EN
    logic irq_en;
    assign irq_bit = irq_en;

    always_ff @(posedge clk_clk) begin
        if (reset_reset)  irq_en <= 1'b0;
        else if (ctrl_wr) irq_en <= avs_writedata[CTRL_IRQ_EN];
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) irq <= 1'b0;
        else             irq <= irq_en & ((out_level != '0) | overflow);
    end
`else
    assign irq_bit = 1'b0;
`endif

    always_comb begin
        status                       = '0;
        status[ST_IN_LEVEL +: 8]     = 8'(in_level);
        status[ST_OUT_LEVEL +: 8]    = 8'(out_level);
        status[ST_IN_FULL]           = in_full;
        status[ST_OUT_EMPTY]         = out_empty;
        status[ST_OVERFLOW]          = overflow;
        status[ST_UNDERFLOW]         = underflow;
    end

    // clear is a write-only strobe, so it always reads back as 0
    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_CTRL: begin
                rd_mux[CTRL_ENABLE] = enable;
                rd_mux[CTRL_IRQ_EN] = irq_bit;
            end
            SEL_STATUS:     rd_mux = status;
            SEL_SAMPLE_OUT: rd_mux = out_empty ? 32'h0 : 32'($signed(out_data));
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            enable            <= 1'b0;
            clear_pulse       <= 1'b0;
            overflow          <= 1'b0;
            underflow         <= 1'b0;
            coef_we           <= 1'b0;
            coef_addr         <= '0;
            coef_data         <= '0;
            rd_valid1         <= 1'b0;
            rd_data1          <= '0;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
        end else begin
            clear_pulse <= 1'b0;
            coef_we     <= 1'b0;
            if (ctrl_wr) begin
                enable      <= avs_writedata[CTRL_ENABLE];
                clear_pulse <= avs_writedata[CTRL_CLEAR];
            end
            if (coef_wr) begin
                coef_we   <= 1'b1;
                coef_addr <= coef_idx[CA_W-1:0];
                coef_data <= avs_writedata[DATA_W-1:0];
            end

            rd_valid1         <= rd_accept;
            rd_data1          <= rd_accept ? rd_mux : 32'h0;
            avs_readdatavalid <= rd_valid1;
            avs_readdata      <= rd_data1;

            // events in the cycle of a STATUS read were not captured, so they win over its clear
            if (clear_pulse) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (rd_status) begin
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                end
                if (ovf_event) overflow  <= 1'b1;
                if (unf_event) underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_mm_responder.sv
// tb/tb_fir_mm_responder.sv - directed register-vector and corner-sequence bench for fir_mm_responder
module tb_fir_mm_responder;

    localparam int DATA_W = 16;

    logic              clk;
    logic              reset;
    logic [9:0]        avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic              avs_burstcount;
    logic              avs_debugaccess;
    logic              avs_waitrequest;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              coef_we;
    logic [5:0]        coef_addr;
    logic [DATA_W-1:0] coef_data;

    int tests  = 0;
    int errors = 0;

    fir_mm_responder dut (
        .clk_clk           (clk),
        .reset_reset       (reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_burstcount    (avs_burstcount),
        .avs_debugaccess   (avs_debugaccess),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .coef_we           (coef_we),
        .coef_addr         (coef_addr),
        .coef_data         (coef_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // tasks start and end at a falling edge
    task automatic mm_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        #1;
        n = 0;
        while (avs_waitrequest && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("write_wait_timeout", 32'(n), 32'd0);
        @(negedge clk);
        avs_write      = 1'b0;
        avs_byteenable = 4'h0;
    endtask

    task automatic mm_read(input logic [9:0] a, input logic with_rx, input logic [DATA_W-1:0] rxd,
                           output logic [31:0] d, output int lat);
        avs_address = a;
        avs_read    = 1'b1;
        if (with_rx) begin
            rx_valid = 1'b1;
            rx_data  = rxd;
        end
        @(negedge clk);
        avs_read = 1'b0;
        rx_valid = 1'b0;
        lat = 1;
        while (!avs_readdatavalid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        d = avs_readdata;
    endtask

    logic [31:0] d;
    int          lat;
    logic        seen;

    initial begin
        reset           = 1'b1;
        avs_address     = '0;
        avs_read        = 1'b0;
        avs_write       = 1'b0;
        avs_writedata   = '0;
        avs_byteenable  = '0;
        avs_burstcount  = 1'b1;
        avs_debugaccess = 1'b0;
        tx_ready        = 1'b0;
        rx_data         = '0;
        rx_valid        = 1'b0;

        vecs.push_back('{1'b0, 10'h000, 32'h0,        4'hF, 32'h0000_0000, "ctrl_reset"});
        vecs.push_back('{1'b0, 10'h004, 32'h0,        4'hF, 32'h0002_0000, "status_reset"});
        vecs.push_back('{1'b1, 10'h000, 32'h1,        4'hF, 32'h0,         "ctrl_wr_en"});
        vecs.push_back('{1'b0, 10'h000, 32'h0,        4'hF, 32'h0000_0001, "ctrl_en"});
        vecs.push_back('{1'b1, 10'h000, 32'h0,        4'hE, 32'h0,         "ctrl_wr_lane0_off"});
        vecs.push_back('{1'b0, 10'h000, 32'h0,        4'hF, 32'h0000_0001, "ctrl_lane_masked"});
        vecs.push_back('{1'b0, 10'h010, 32'h0,        4'hF, 32'h0000_0000, "unmapped_read"});
        vecs.push_back('{1'b1, 10'h008, 32'h5,        4'h3, 32'h0,         "sample_in_wr"});
        vecs.push_back('{1'b0, 10'h004, 32'h0,        4'hF, 32'h0002_0001, "status_in_lvl1"});
        vecs.push_back('{1'b1, 10'h008, 32'h6,        4'h1, 32'h0,         "sample_in_partial"});
        vecs.push_back('{1'b0, 10'h004, 32'h0,        4'hF, 32'h0002_0001, "status_partial_drop"});
        vecs.push_back('{1'b0, 10'h00B, 32'h0,        4'hF, 32'h0000_0000, "sample_in_read"});
        vecs.push_back('{1'b0, 10'h00D, 32'h0,        4'hF, 32'h0000_0000, "sample_out_empty"});
        vecs.push_back('{1'b0, 10'h004, 32'h0,        4'hF, 32'h000A_0001, "status_underflow"});
        vecs.push_back('{1'b0, 10'h004, 32'h0,        4'hF, 32'h0002_0001, "status_sticky_clr"});
        vecs.push_back('{1'b0, 10'h104, 32'h0,        4'hF, 32'h0000_0000, "coef_read"});
        vecs.push_back('{1'b1, 10'h000, 32'h2,        4'hF, 32'h0,         "ctrl_clear"});
        vecs.push_back('{1'b0, 10'h000, 32'h0,        4'hF, 32'h0000_0000, "ctrl_after_clear"});
        vecs.push_back('{1'b0, 10'h004, 32'h0,        4'hF, 32'h0002_0000, "status_after_clear"});

        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_readdatavalid", 32'(avs_readdatavalid), 32'd0);
        check("rst_readdata",      avs_readdata,           32'd0);
        check("rst_tx_valid",      32'(tx_valid),          32'd0);
        check("rst_coef_we",       32'(coef_we),           32'd0);
        check("rst_waitrequest",   32'(avs_waitrequest),   32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                mm_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            end else begin
                mm_read(vecs[i].addr, 1'b0, '0, d, lat);
                check({vecs[i].name, "_data"}, d, vecs[i].exp);
                check({vecs[i].name, "_lat"}, 32'(lat), 32'd2);
            end
        end

        // back-to-back reads: one result per cycle, in order
        avs_address = 10'h000;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_address = 10'h004;
        check("b2b_no_early_valid", 32'(avs_readdatavalid), 32'd0);
        @(negedge clk);
        avs_read = 1'b0;
        check("b2b_valid0", 32'(avs_readdatavalid), 32'd1);
        check("b2b_data0",  avs_readdata,           32'h0000_0000);
        @(negedge clk);
        check("b2b_valid1", 32'(avs_readdatavalid), 32'd1);
        check("b2b_data1",  avs_readdata,           32'h0002_0000);
        @(negedge clk);
        check("b2b_valid_end", 32'(avs_readdatavalid), 32'd0);

        // coefficient writes
        check("coef_we_idle", 32'(coef_we), 32'd0);
        mm_write(10'h10C, 32'h0000_1234, 4'hF);
        check("coef_we_pulse", 32'(coef_we),   32'd1);
        check("coef_addr3",    32'(coef_addr), 32'd3);
        check("coef_data",     32'(coef_data), 32'h1234);
        @(negedge clk);
        check("coef_we_one_cycle", 32'(coef_we), 32'd0);
        mm_write(10'h1FC, 32'hABCD_BEEF, 4'h3);
        check("coef63_we",   32'(coef_we),   32'd1);
        check("coef63_addr", 32'(coef_addr), 32'd63);
        check("coef63_data", 32'(coef_data), 32'hBEEF);
        mm_write(10'h110, 32'h0000_5555, 4'h1);
        check("coef_partial_drop", 32'(coef_we), 32'd0);
        mm_write(10'h200, 32'h0000_5555, 4'hF);
        check("coef_out_of_range", 32'(coef_we), 32'd0);

        // input FIFO fill, stall on the 17th push, release by one tx_ready cycle
        mm_write(10'h000, 32'h1, 4'hF);
        for (int i = 0; i < 16; i++) mm_write(10'h008, 32'(100 + i), 4'h3);
        check("tx_valid_full", 32'(tx_valid), 32'd1);
        check("tx_data_head",  32'(tx_data),  32'd100);
        mm_read(10'h004, 1'b0, '0, d, lat);
        check("status_in_full", d, 32'h0003_0010);
        avs_address    = 10'h008;
        avs_writedata  = 32'd116;
        avs_byteenable = 4'h3;
        avs_write      = 1'b1;
        #1;
        check("wait_on_full", 32'(avs_waitrequest), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("wait_held", 32'(avs_waitrequest), 32'd1);
            check("tx_data_stable", 32'(tx_data), 32'd100);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        #1;
        check("wait_released", 32'(avs_waitrequest), 32'd0);
        check("tx_data_after_pop", 32'(tx_data), 32'd101);
        @(negedge clk);
        avs_write = 1'b0;
        mm_read(10'h004, 1'b0, '0, d, lat);
        check("status_refilled", d, 32'h0003_0010);
        for (int k = 0; k < 16; k++) begin
            tx_ready = 1'b1;
            check("drain_valid", 32'(tx_valid), 32'd1);
            check("drain_data",  32'(tx_data),  32'(101 + k));
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("drain_done", 32'(tx_valid), 32'd0);

        // output FIFO overflow, simultaneous push/pop at full, sign extension
        rx_valid = 1'b1;
        rx_data  = 16'h8001;
        repeat (17) @(negedge clk);
        rx_valid = 1'b0;
        mm_read(10'h004, 1'b0, '0, d, lat);
        check("status_overflow", d, 32'h0004_1000);
        mm_read(10'h00C, 1'b1, 16'h1234, d, lat);
        check("sample_out_sext", d, 32'hFFFF_8001);
        mm_read(10'h004, 1'b0, '0, d, lat);
        check("status_push_pop_full", d, 32'h0000_1000);
        mm_read(10'h00C, 1'b0, '0, d, lat);
        check("sample_out_second", d, 32'hFFFF_8001);
        mm_read(10'h004, 1'b0, '0, d, lat);
        check("status_lvl15", d, 32'h0000_0F00);
        mm_write(10'h000, 32'h3, 4'h1);
        mm_read(10'h000, 1'b0, '0, d, lat);
        check("ctrl_keep_enable", d, 32'h0000_0001);
        mm_read(10'h004, 1'b0, '0, d, lat);
        check("status_cleared", d, 32'h0002_0000);

        // reset one cycle after an accepted read drops its response
        rx_valid = 1'b1;
        rx_data  = 16'h0042;
        avs_address = 10'h004;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (avs_readdatavalid) seen = 1'b1;
            @(negedge clk);
        end
        check("no_valid_after_reset", 32'(seen), 32'd0);
        check("readdata_after_reset", avs_readdata, 32'd0);
        mm_read(10'h000, 1'b0, '0, d, lat);
        check("ctrl_after_reset", d, 32'h0000_0000);
        mm_read(10'h004, 1'b0, '0, d, lat);
        check("status_after_reset", d, 32'h0002_0000);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
